// File: rtl/mdu_seq.sv
// mdu_seq: iterative radix-2 shift-add multiplier and restoring shift-subtract divider.
// Signed operands run as magnitudes; the FIX state applies sign correction and registers results.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             Abort,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ResultHi,
    output logic [WIDTH-1:0] ResultLo,
    output logic             DivZero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, done_q, divzero_q;
    logic [WIDTH-1:0] res_hi_q, res_lo_q;

    // Working registers: hi = partial product / remainder, lo = multiplier / quotient
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic            is_div_q, is_div_d, negp_q, negp_d, negr_q, negr_d, dz_q, dz_d;

    logic            start_ok;
    logic            sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]  sum, rem_sh;
    logic [WIDTH-1:0] diff;
    logic            ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fix_hi, fix_lo;
    logic            fix_dz;

    assign start_ok = Start && (state_q == S_IDLE || state_q == S_DONE);
    assign sign_a   = Op[0] && SrcA[WIDTH-1];
    assign sign_b   = Op[0] && SrcB[WIDTH-1];
    assign mag_a    = Op[0] ? magnitude(SrcA) : SrcA;
    assign mag_b    = Op[0] ? magnitude(SrcB) : SrcB;

    assign sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign rem_sh = {hi_q, lo_q[WIDTH-1]};
    assign ge     = rem_sh >= {1'b0, b_q};
    assign diff   = rem_sh[WIDTH-1:0] - b_q;

    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        negp_d   = negp_q;
        negr_d   = negr_q;
        dz_d     = dz_q;
        if (start_ok) begin
            hi_d     = '0;
            lo_d     = Op[1] ? mag_a : mag_b;
            b_d      = Op[1] ? mag_b : mag_a;
            is_div_d = Op[1];
            negp_d   = sign_a ^ sign_b;
            negr_d   = Op[1] && sign_a;
            dz_d     = Op[1] && (SrcB == '0);
        end else if (state_q == S_RUN) begin
            if (is_div_q) begin
                hi_d = ge ? diff : rem_sh[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], ge};
            end else begin
                hi_d = sum[WIDTH:1];
                lo_d = {sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        prod   = negate_2w({hi_q, lo_q}, negp_q);
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        fix_dz = 1'b0;
        if (is_div_q) begin
            fix_hi = negate_w(hi_q, negr_q);
            fix_lo = dz_q ? '1 : negate_w(lo_q, negp_q);
            fix_dz = dz_q;
        end
    end

    // Datapath stage: operand load and one iteration per RUN cycle
    always_ff @(posedge clk) begin
        hi_q     <= hi_d;
        lo_q     <= lo_d;
        b_q      <= b_d;
        is_div_q <= is_div_d;
        negp_q   <= negp_d;
        negr_q   <= negr_d;
        dz_q     <= dz_d;
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
            res_hi_q  <= '0;
            res_lo_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (Abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_FIX: begin
                    state_q <= Abort ? S_IDLE : S_DONE;
                    busy_q  <= 1'b0;
                    if (!Abort) begin
                        done_q    <= 1'b1;
                        res_hi_q  <= fix_hi;
                        res_lo_q  <= fix_lo;
                        divzero_q <= fix_dz;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign ResultHi = res_hi_q;
    assign ResultLo = res_lo_q;
    assign DivZero  = divzero_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed testbench for mdu_seq (WIDTH=32): latency, arithmetic corner cases, handshake, reset and abort.
module tb_mdu_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic        Abort = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        Busy, Done, DivZero;
    logic [31:0] ResultHi, ResultLo;

    int checks = 0;
    int errors = 0;

    mdu_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Abort(Abort), .Op(Op),
        .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done),
        .ResultHi(ResultHi), .ResultLo(ResultLo), .DivZero(DivZero)
    );

    always #5 clk = ~clk;

    // Present an op for one edge, then scramble inputs so latching is exercised.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Op = op; SrcA = a; SrcB = b; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0; Op = ~op; SrcA = 32'h5A5A_A5A5; SrcB = 32'h0;
    endtask

    // Returns edges after the Start edge until Done is seen; 0 on timeout.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (Done) begin n = i; break; end
        end
    endtask

    task automatic test_reset;
        #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", Done); end
        checks++; if ({ResultHi, ResultLo} !== 64'h0) begin errors++; $display("FAIL reset_result got %h_%h exp 0", ResultHi, ResultLo); end
        checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL reset_divzero got %b exp 0", DivZero); end
        #20 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_umul;
        int n;
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL umul_busy got %b exp 1", Busy); end
        wait_done(n);
        checks++; if (n !== 33) begin errors++; $display("FAIL umul_latency got %0d exp 33", n); end
        checks++; if (ResultHi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL umul_hi got %h exp FFFFFFFE", ResultHi); end
        checks++; if (ResultLo !== 32'h0000_0001) begin errors++; $display("FAIL umul_lo got %h exp 00000001", ResultLo); end
        checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL umul_dz got %b exp 0", DivZero); end
        @(posedge clk); #1;
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL umul_done_width got %b exp 0", Done); end
    endtask

    task automatic test_smul;
        int n;
        issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_done(n);
        checks++; if ({ResultHi, ResultLo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL smul_neg got %h_%h exp FFFFFFFF_FFFFFFFE", ResultHi, ResultLo); end
        issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_done(n);
        checks++; if ({ResultHi, ResultLo} !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL umul_same got %h_%h exp 00000001_FFFFFFFE", ResultHi, ResultLo); end
        issue(2'b01, 32'hFFFF_FFFD, 32'hFFFF_FFFB);
        wait_done(n);
        checks++; if ({ResultHi, ResultLo} !== 64'h0000_0000_0000_000F) begin errors++; $display("FAIL smul_negneg got %h_%h exp 00000000_0000000F", ResultHi, ResultLo); end
    endtask

    task automatic test_div;
        int n;
        issue(2'b10, 32'd100, 32'd7);
        wait_done(n);
        checks++; if ({ResultHi, ResultLo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL udiv_100_7 got %h_%h exp 00000002_0000000E", ResultHi, ResultLo); end
        issue(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        checks++; if ({ResultHi, ResultLo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL sdiv_m7_2 got %h_%h exp FFFFFFFF_FFFFFFFD", ResultHi, ResultLo); end
        issue(2'b11, 32'd7, 32'hFFFF_FFFE);
        wait_done(n);
        checks++; if ({ResultHi, ResultLo} !== 64'h0000_0001_FFFF_FFFD) begin errors++; $display("FAIL sdiv_7_m2 got %h_%h exp 00000001_FFFFFFFD", ResultHi, ResultLo); end
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        checks++; if ({ResultHi, ResultLo, DivZero} !== {32'h0, 32'h8000_0000, 1'b0}) begin errors++; $display("FAIL sdiv_min_m1 got %h_%h dz %b exp 00000000_80000000 dz 0", ResultHi, ResultLo, DivZero); end
    endtask

    task automatic test_divzero;
        int n;
        issue(2'b10, 32'h0000_1234, 32'h0);
        wait_done(n);
        checks++; if (n !== 33) begin errors++; $display("FAIL udiv0_latency got %0d exp 33", n); end
        checks++; if ({ResultHi, ResultLo, DivZero} !== {32'h0000_1234, 32'hFFFF_FFFF, 1'b1}) begin errors++; $display("FAIL udiv0 got %h_%h dz %b exp 00001234_FFFFFFFF dz 1", ResultHi, ResultLo, DivZero); end
        issue(2'b11, 32'hFFFF_FF00, 32'h0);
        wait_done(n);
        checks++; if ({ResultHi, ResultLo, DivZero} !== {32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1}) begin errors++; $display("FAIL sdiv0 got %h_%h dz %b exp FFFFFF00_FFFFFFFF dz 1", ResultHi, ResultLo, DivZero); end
        issue(2'b00, 32'd3, 32'd5);
        wait_done(n);
        checks++; if ({ResultHi, ResultLo, DivZero} !== {32'h0, 32'd15, 1'b0}) begin errors++; $display("FAIL mul_clears_dz got %h_%h dz %b exp 00000000_0000000F dz 0", ResultHi, ResultLo, DivZero); end
    endtask

    task automatic test_start_ignored;
        int n;
        issue(2'b00, 32'h0001_0000, 32'h0001_0000);
        repeat (4) begin @(posedge clk); #1; end
        Start = 1'b1; Op = 2'b10; SrcA = 32'd99; SrcB = 32'd3;
        @(posedge clk); #1;
        Start = 1'b0;
        wait_done(n);
        checks++; if (n + 5 !== 33) begin errors++; $display("FAIL ignored_latency got %0d exp 33", n + 5); end
        checks++; if ({ResultHi, ResultLo} !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL ignored_result got %h_%h exp 00000001_00000000", ResultHi, ResultLo); end
        @(posedge clk); #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL ignored_no_queue got busy %b exp 0", Busy); end
    endtask

    task automatic test_back_to_back;
        int n;
        issue(2'b10, 32'd100, 32'd7);
        wait_done(n);
        checks++; if ({ResultHi, ResultLo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL b2b_first got %h_%h exp 00000002_0000000E", ResultHi, ResultLo); end
        Abort = 1'b1;
        issue(2'b00, 32'd6, 32'd7);
        Abort = 1'b0;
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL b2b_no_idle got busy %b exp 1", Busy); end
        wait_done(n);
        checks++; if (n !== 33) begin errors++; $display("FAIL b2b_latency got %0d exp 33", n); end
        checks++; if ({ResultHi, ResultLo} !== {32'd0, 32'd42}) begin errors++; $display("FAIL b2b_second got %h_%h exp 00000000_0000002A", ResultHi, ResultLo); end
    endtask

    task automatic test_reset_mid_run;
        int seen;
        issue(2'b10, 32'h0000_1234, 32'h0);
        repeat (10) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        checks++; if ({Busy, Done, DivZero} !== 3'b000) begin errors++; $display("FAIL midreset_flags got %b exp 000", {Busy, Done, DivZero}); end
        checks++; if ({ResultHi, ResultLo} !== 64'h0) begin errors++; $display("FAIL midreset_result got %h_%h exp 0", ResultHi, ResultLo); end
        #2 reset = 1'b0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (Done || Busy) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_done got %0d active cycles exp 0", seen); end
    endtask

    task automatic test_abort_fix;
        int n, seen;
        issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_done(n);
        issue(2'b00, 32'd3, 32'd5);
        repeat (32) begin @(posedge clk); #1; end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL abort_in_fix_busy got %b exp 1", Busy); end
        Abort = 1'b1;
        @(posedge clk); #1;
        Abort = 1'b0;
        checks++; if ({Busy, Done} !== 2'b00) begin errors++; $display("FAIL abort_drop got busy/done %b exp 00", {Busy, Done}); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (Done) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", seen); end
        checks++; if ({ResultHi, ResultLo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL abort_retain got %h_%h exp FFFFFFFF_FFFFFFFE", ResultHi, ResultLo); end
    endtask

    initial begin
        test_reset();
        test_umul();
        test_smul();
        test_div();
        test_divzero();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_abort_fix();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
